// File: rtl/maze_pkg.sv
// Shared scan-code constants, direction and decoder-state types for the maze move controller.
package maze_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_L,
    DIR_R,
    DIR_U,
    DIR_D
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

  function automatic dir_t arrow_dir(input logic [7:0] code);
    case (code)
      SC_LEFT:  return DIR_L;
      SC_RIGHT: return DIR_R;
      SC_UP:    return DIR_U;
      SC_DOWN:  return DIR_D;
      default:  return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/maze_move_ctrl_if.sv
// Key input, maze description and player-position signals of the maze move controller.
interface maze_move_ctrl_if;

  logic         enable;
  logic         load;
  logic [7:0]   key_code;
  logic         key_valid;
  logic [255:0] maze_data;
  logic [4:0]   maze_width;
  logic [4:0]   maze_height;
  logic [3:0]   start_x;
  logic [3:0]   start_y;
  logic [3:0]   goal_x;
  logic [3:0]   goal_y;
  logic [3:0]   curr_x;
  logic [3:0]   curr_y;
  logic         moved;
  logic         blocked;
  logic         at_goal;

  modport master (
    output enable, load, key_code, key_valid, maze_data, maze_width, maze_height,
           start_x, start_y, goal_x, goal_y,
    input  curr_x, curr_y, moved, blocked, at_goal
  );

  modport slave (
    input  enable, load, key_code, key_valid, maze_data, maze_width, maze_height,
           start_x, start_y, goal_x, goal_y,
    output curr_x, curr_y, moved, blocked, at_goal
  );

endinterface

// File: rtl/maze_move_ctrl_ps2_arrow_decoder.sv
// PS/2 set-2 arrow-key decoder: registered make/break pulses one cycle after the final byte.
module ps2_arrow_decoder
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       make_pulse,
  output logic       break_pulse,
  output dir_t       dir
);

  dec_state_t state_q, state_d;
  logic       make_q, make_d;
  logic       brk_q, brk_d;
  dir_t       dir_q, dir_d;
  dir_t       arrow;

  always_comb begin
    state_d = state_q;
    make_d  = 1'b0;
    brk_d   = 1'b0;
    dir_d   = dir_q;
    arrow   = arrow_dir(key_code);
    if (key_valid) begin
      case (state_q)
        IDLE: begin
          if (key_code == SC_EXT)      state_d = EXT;
          else if (key_code == SC_BRK) state_d = BRK;
        end
        EXT: begin
          if (key_code == SC_BRK) begin
            state_d = EXT_BRK;
          end else begin
            state_d = IDLE;
            if (arrow != DIR_NONE) begin
              make_d = 1'b1;
              dir_d  = arrow;
            end
          end
        end
        BRK: state_d = IDLE;
        EXT_BRK: begin
          state_d = IDLE;
          if (arrow != DIR_NONE) begin
            brk_d = 1'b1;
            dir_d = arrow;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      make_q  <= 1'b0;
      brk_q   <= 1'b0;
      dir_q   <= DIR_NONE;
    end else begin
      state_q <= state_d;
      make_q  <= make_d;
      brk_q   <= brk_d;
      dir_q   <= dir_d;
    end
  end

  assign make_pulse  = make_q;
  assign break_pulse = brk_q;
  assign dir         = dir_q;

endmodule

// File: rtl/maze_move_ctrl.sv
// Player position controller: held-direction auto-repeat plus bounds/wall check on each move attempt.
// A decoded make lands in curr/moved/blocked two cycles after its key_valid.
module maze_move_ctrl
  import maze_pkg::*;
#(
  parameter int REPEAT_TICKS = 12_500_000,
  parameter int CNT_W        = 24
) (
  input  logic              clk,
  input  logic              reset,
  maze_move_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic       dec_make;
  logic       dec_brk;
  dir_t       dec_dir;

  dir_t             held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       curr_x_q, curr_x_d;
  logic [3:0]       curr_y_q, curr_y_d;
  logic             moved_q, moved_d;
  logic             blocked_q, blocked_d;
  logic             at_goal_q, at_goal_d;

  logic       req;
  dir_t       req_dir;
  logic [4:0] tgt_x, tgt_y;
  logic       tgt_ok;

  ps2_arrow_decoder u_dec (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (bus.key_valid),
    .key_code    (bus.key_code),
    .make_pulse  (dec_make),
    .break_pulse (dec_brk),
    .dir         (dec_dir)
  );

  // Held direction and repeat timer; a fresh direction moves at once and restarts the period.
  always_comb begin
    held_d  = held_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    req_dir = held_q;
    if (dec_make && (dec_dir != held_q)) begin
      held_d  = dec_dir;
      cnt_d   = '0;
      req     = 1'b1;
      req_dir = dec_dir;
    end else begin
      if (dec_brk && (dec_dir == held_q)) held_d = DIR_NONE;
      if (held_d == DIR_NONE) begin
        cnt_d = '0;
      end else if (bus.enable) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          req   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    if (bus.load) begin
      held_d = DIR_NONE;
      cnt_d  = '0;
    end
  end

  // 5-bit target: stepping left/up from 0 gives 31, which the bounds test rejects.
  always_comb begin
    tgt_x = {1'b0, curr_x_q};
    tgt_y = {1'b0, curr_y_q};
    case (req_dir)
      DIR_L:   tgt_x = tgt_x - 5'd1;
      DIR_R:   tgt_x = tgt_x + 5'd1;
      DIR_U:   tgt_y = tgt_y - 5'd1;
      DIR_D:   tgt_y = tgt_y + 5'd1;
      default: ;
    endcase
    tgt_ok = (tgt_x < bus.maze_width) && (tgt_y < bus.maze_height) &&
             bus.maze_data[{tgt_y[3:0], tgt_x[3:0]}];
  end

  always_comb begin
    curr_x_d  = curr_x_q;
    curr_y_d  = curr_y_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    at_goal_d = (curr_x_q == bus.goal_x) && (curr_y_q == bus.goal_y);
    if (bus.load) begin
      curr_x_d = bus.start_x;
      curr_y_d = bus.start_y;
    end else if (req && bus.enable) begin
      if (tgt_ok) begin
        curr_x_d = tgt_x[3:0];
        curr_y_d = tgt_y[3:0];
        moved_d  = 1'b1;
      end else begin
        blocked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q    <= DIR_NONE;
      cnt_q     <= '0;
      curr_x_q  <= 4'd0;
      curr_y_q  <= 4'd0;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
      at_goal_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      cnt_q     <= cnt_d;
      curr_x_q  <= curr_x_d;
      curr_y_q  <= curr_y_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
      at_goal_q <= at_goal_d;
    end
  end

  assign bus.curr_x  = curr_x_q;
  assign bus.curr_y  = curr_y_q;
  assign bus.moved   = moved_q;
  assign bus.blocked = blocked_q;
  assign bus.at_goal = at_goal_q;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed bench for maze_move_ctrl: vector table of single taps plus repeat/priority sequences.
module tb_maze_move_ctrl;
  import maze_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  maze_move_ctrl_if bus ();

  maze_move_ctrl #(.REPEAT_TICKS(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0] sx, sy;
    logic [4:0] w, h;
    logic [7:0] code;
    int         ex, ey, mv, bl, goal;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    @(negedge clk);
    bus.key_valid = v;
    bus.key_code  = b;
  endtask

  task automatic do_load(input logic [3:0] sx, input logic [3:0] sy);
    bus.start_x = sx;
    bus.start_y = sy;
    @(negedge clk);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Press then release one extended key; outputs sampled two cycles after the make byte.
  task automatic tap(input string nm, input logic [7:0] code,
                     input int ex, input int ey, input int emv, input int ebl, input int egoal);
    drive(1'b1, SC_EXT);
    drive(1'b1, code);
    drive(1'b1, SC_EXT);
    @(negedge clk);
    chk({nm, ".x"}, int'(bus.curr_x), ex);
    chk({nm, ".y"}, int'(bus.curr_y), ey);
    chk({nm, ".moved"}, int'(bus.moved), emv);
    chk({nm, ".blocked"}, int'(bus.blocked), ebl);
    bus.key_code = SC_BRK;
    @(negedge clk);
    chk({nm, ".at_goal"}, int'(bus.at_goal), egoal);
    chk({nm, ".pulse_end"}, int'(bus.moved | bus.blocked), 0);
    bus.key_code = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [255:0] maze;
    int exp_x, exp_y;

    maze     = '1;
    maze[17] = 1'b0;
    maze[67] = 1'b0;

    bus.enable      = 1'b1;
    bus.load        = 1'b0;
    bus.key_code    = 8'h00;
    bus.key_valid   = 1'b0;
    bus.maze_data   = maze;
    bus.maze_width  = 5'd16;
    bus.maze_height = 5'd16;
    bus.start_x     = 4'd0;
    bus.start_y     = 4'd0;
    bus.goal_x      = 4'd0;
    bus.goal_y      = 4'd0;

    vecs[0]  = '{4'd0,  4'd0,  5'd16, 5'd16, SC_RIGHT, 1,  0,  1, 0, 0};
    vecs[1]  = '{4'd1,  4'd0,  5'd16, 5'd16, SC_DOWN,  1,  0,  0, 1, 0};
    vecs[2]  = '{4'd2,  4'd0,  5'd3,  5'd16, SC_RIGHT, 2,  0,  0, 1, 0};
    vecs[3]  = '{4'd0,  4'd0,  5'd16, 5'd16, SC_LEFT,  0,  0,  0, 1, 0};
    vecs[4]  = '{4'd0,  4'd15, 5'd16, 5'd16, SC_DOWN,  0,  15, 0, 1, 0};
    vecs[5]  = '{4'd0,  4'd0,  5'd16, 5'd16, SC_UP,    0,  0,  0, 1, 0};
    vecs[6]  = '{4'd15, 4'd3,  5'd16, 5'd16, SC_RIGHT, 15, 3,  0, 1, 0};
    vecs[7]  = '{4'd2,  4'd1,  5'd16, 5'd16, SC_LEFT,  2,  1,  0, 1, 0};
    vecs[8]  = '{4'd3,  4'd3,  5'd16, 5'd16, SC_DOWN,  3,  3,  0, 1, 0};
    vecs[9]  = '{4'd3,  4'd5,  5'd16, 5'd16, SC_UP,    3,  5,  0, 1, 0};
    vecs[10] = '{4'd5,  4'd5,  5'd16, 5'd16, SC_UP,    5,  4,  1, 0, 0};
    vecs[11] = '{4'd5,  4'd5,  5'd16, 5'd16, SC_LEFT,  4,  5,  1, 0, 0};
    vecs[12] = '{4'd0,  4'd2,  5'd16, 5'd3,  SC_DOWN,  0,  2,  0, 1, 0};
    vecs[13] = '{4'd14, 4'd14, 5'd16, 5'd16, SC_DOWN,  14, 15, 1, 0, 1};

    // Reset state, with goal at the origin so at_goal must be held low by reset.
    bus.load = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.x", int'(bus.curr_x), 0);
    chk("rst.y", int'(bus.curr_y), 0);
    chk("rst.moved", int'(bus.moved), 0);
    chk("rst.blocked", int'(bus.blocked), 0);
    chk("rst.at_goal", int'(bus.at_goal), 0);
    bus.load = 1'b0;
    reset    = 1'b0;
    bus.goal_x = 4'd14;
    bus.goal_y = 4'd15;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      bus.maze_width  = vecs[i].w;
      bus.maze_height = vecs[i].h;
      do_load(vecs[i].sx, vecs[i].sy);
      tap($sformatf("vec%0d", i), vecs[i].code, vecs[i].ex, vecs[i].ey,
          vecs[i].mv, vecs[i].bl, vecs[i].goal);
    end
    bus.maze_width  = 5'd16;
    bus.maze_height = 5'd16;

    // Hold RIGHT with no break: x steps every 4 cycles until the release lands.
    do_load(4'd0, 4'd0);
    drive(1'b1, SC_EXT);
    drive(1'b1, SC_RIGHT);
    for (int t = 1; t <= 25; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        exp_x = 1 + (((t - 2) < 12 ? (t - 2) : 12) / 4);
        chk($sformatf("rpt.x.t%0d", t), int'(bus.curr_x), exp_x);
      end
      bus.key_valid = (t >= 12 && t <= 14);
      bus.key_code  = (t == 12) ? SC_EXT : (t == 13) ? SC_BRK : SC_RIGHT;
    end
    chk("rpt.y", int'(bus.curr_y), 0);

    // Hold RIGHT, press UP, release RIGHT: UP stays held and keeps repeating.
    do_load(4'd2, 4'd10);
    drive(1'b1, SC_EXT);
    drive(1'b1, SC_RIGHT);
    for (int t = 1; t <= 19; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        exp_x = (t <= 5) ? 3 : 4;
        exp_y = (t <= 6) ? 10 : (t <= 10) ? 9 : (t <= 14) ? 8 : (t <= 18) ? 7 : 6;
        chk($sformatf("hold.x.t%0d", t), int'(bus.curr_x), exp_x);
        chk($sformatf("hold.y.t%0d", t), int'(bus.curr_y), exp_y);
      end
      bus.key_valid = (t == 4 || t == 5 || t == 7 || t == 8 || t == 9);
      case (t)
        4, 7:    bus.key_code = SC_EXT;
        5:       bus.key_code = SC_UP;
        8:       bus.key_code = SC_BRK;
        default: bus.key_code = SC_RIGHT;
      endcase
    end
    bus.key_valid = 1'b0;

    // Disabled: the press is dropped and nothing fires once enable returns.
    do_load(4'd6, 4'd6);
    bus.enable = 1'b0;
    tap("dis", SC_RIGHT, 6, 6, 0, 0, 0);
    bus.enable = 1'b1;
    repeat (8) @(negedge clk);
    chk("dis.after.x", int'(bus.curr_x), 6);
    chk("dis.after.moved", int'(bus.moved), 0);

    // Reset between E0 and the arrow byte kills the pending extended prefix.
    drive(1'b1, SC_EXT);
    @(negedge clk);
    bus.key_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, SC_RIGHT);
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("rstmid.x", int'(bus.curr_x), 0);
    chk("rstmid.y", int'(bus.curr_y), 0);
    chk("rstmid.moved", int'(bus.moved), 0);
    repeat (6) @(negedge clk);
    chk("rstmid.late.x", int'(bus.curr_x), 0);

    // Load in the same cycle as the move: start position wins, held direction cleared.
    do_load(4'd6, 4'd6);
    bus.start_x = 4'd9;
    bus.start_y = 4'd9;
    drive(1'b1, SC_EXT);
    drive(1'b1, SC_RIGHT);
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("ldmv.x", int'(bus.curr_x), 9);
    chk("ldmv.y", int'(bus.curr_y), 9);
    chk("ldmv.moved", int'(bus.moved), 0);
    repeat (6) @(negedge clk);
    chk("ldmv.late.x", int'(bus.curr_x), 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
